sprite_line_scheduler: RTL and testbench
========================================

Name: sprite_line_scheduler

Overview:
- Per-scanline controller for the sprite pixel fetcher (print_sprite).
- On each line_start it walks the object table and tests each valid entry for vertical overlap with ycoor.
- For every hit it drives object_info and runs the start/ready handshake with the fetcher, one sprite at a time.
- Sits between the frame/object-table logic and the line-buffer fill path.

Parameters:
- NUM_OBJ, 16, object table entries.
- ADDR_W, 4, object table address width; NUM_OBJ <= 2**ADDR_W.
- SPRITE_H, 32, sprite height in lines.
- MAX_PER_LINE, 8, per-line sprite cap; used only with SPRITE_LIMIT_EN.

Ports:
- clk50  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- line_start  in  1  one-cycle pulse, begin a scanline.
- ycoor  in  10  current scanline; sampled at line_start.
- obj_addr  out  ADDR_W  object table read address.
- obj_data  in  24  table read data; valid one cycle after obj_addr. Fields: [23] valid, [22:19] sprite id, [18:9] x, [8:0] y.
- object_info  out  24  entry being drawn; held stable for the whole handshake.
- sprite_start  out  1  start to fetcher.
- sprite_ready  in  1  ready from fetcher.
- busy  out  1  high from accepted line_start until line_done.
- line_done  out  1  one-cycle pulse, line complete.
- line_overrun  out  1  one-cycle pulse, line_start arrived while busy.
- sprites_drawn  out  5  hits handshaken this line; held until next accepted line_start.

Behaviour:
- Reset (reset==0 at clk50 edge):
  - state=IDLE; obj_addr=0; object_info=0.
  - sprite_start, busy, line_done, line_overrun = 0; sprites_drawn=0.
  - Reset mid-handshake drops sprite_start the next cycle. No wait on the fetcher.
- IDLE:
  - On line_start: latch ycoor into y_lat, set idx=0, clear sprites_drawn, set busy=1, go to FETCH.
- FETCH:
  - obj_addr=idx; go to CHECK.
- CHECK (obj_data valid this cycle):
  - diff = y_lat - {1'b0,obj_data[8:0]}, 10-bit unsigned.
  - hit = obj_data[23] & (y_lat >= obj_data[8:0]) & (diff < SPRITE_H).
  - On hit: register object_info=obj_data, go to START.
  - On miss: go to NEXT.
- START:
  - sprite_start=1.
  - Stay while sprite_ready==0.
  - When sprite_ready==1: sprites_drawn+=1 (saturates at 31), go to RELEASE.
- RELEASE:
  - sprite_start=0.
  - Stay while sprite_ready==1; when 0, go to NEXT. This prevents a stale ready being taken for the next sprite.
- NEXT:
  - If idx==NUM_OBJ-1, go to DONE; else idx+=1 and go to FETCH.
- DONE:
  - line_done=1 for one cycle; busy=0 the following cycle; go to IDLE.
- Latency:
  - Miss costs 3 cycles per entry (FETCH, CHECK, NEXT).
  - Hit costs 3 cycles plus the handshake time.
  - Empty table with NUM_OBJ=16: line_done 48 cycles after line_start plus 1 (DONE).
- line_start while busy:
  - Ignored; line_overrun pulses in the same cycle.
  - Current line continues unaffected.
- line_start coincident with the DONE cycle:
  - Counts as busy: overrun pulse, line not restarted.
- ycoor is don't-care except at line_start.
- object_info changes only in CHECK on a hit.
- y near 511 with a y_lat wrap is excluded by the y_lat >= y term.

Optional Feature:
- Macro: SPRITE_LIMIT_EN.
- Defined:
  - When sprites_drawn reaches MAX_PER_LINE on leaving RELEASE, go directly to DONE.
  - Remaining entries are skipped.
  - An extra output limit_hit (1 bit) pulses with line_done when the cap was reached.
- Undefined:
  - All NUM_OBJ entries are scanned.
  - No limit_hit port.

Decomposition:
- Package sprite_pkg holds:
  - state enum sched_st_t {IDLE, FETCH, CHECK, START, RELEASE, NEXT, DONE};
  - field constants OBJ_VALID_BIT=23, OBJ_X_MSB=18, OBJ_X_LSB=9, OBJ_Y_MSB=8;
  - SPRITE_W=32 and SPRITE_H default.
- Optional sub-module sprite_y_hit: combinational hit test (y_lat, obj_y, valid -> hit). It is shared with any later priority logic.

Test Plan:
- Empty table (all valid=0), line_start with ycoor=100 -> no sprite_start; line_done at cycle 49; sprites_drawn=0.
- Entry 3 = {valid, y=90, x=200}, ycoor=100 -> one handshake with object_info[18:9]=200; sprites_drawn=1.
- Same entry, ycoor=121 (diff 31) and 122 (diff 32) -> hit at 121, miss at 122.
- Fetcher holds sprite_ready high for 5 cycles after start drops -> scheduler stays in RELEASE; no second start until ready=0.
- line_start pulsed while busy -> line_overrun=1 for one cycle; sprites_drawn and line_done match an uninterrupted line.
- SPRITE_LIMIT_EN, MAX_PER_LINE=2, 4 hitting entries -> exactly 2 handshakes; limit_hit and line_done pulse together. Also: reset low mid-START -> sprite_start=0 and busy=0 next cycle.

Source files
------------

// File: rtl/sprite_line_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// sprite_pkg
// Shared definitions for the sprite line scheduler and its hit-test helper:
// the scheduler state encoding, the object-table entry field positions and
// the default sprite dimensions.
// No ports (package).
// ---------------------------------------------------------------------------
package sprite_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        CHECK,
        START,
        RELEASE,
        NEXT,
        DONE
    } sched_st_t;

    // Object table entry layout: [23] valid, [22:19] id, [18:9] x, [8:0] y
    localparam int OBJ_VALID_BIT = 23;
    localparam int OBJ_X_MSB     = 18;
    localparam int OBJ_X_LSB     = 9;
    localparam int OBJ_Y_MSB     = 8;

    localparam int SPRITE_W         = 32;
    localparam int SPRITE_H_DEFAULT = 32;

endpackage

// File: rtl/sprite_line_scheduler_y_hit.sv
// ---------------------------------------------------------------------------
// sprite_y_hit
// Combinational vertical-overlap test of one object against the current line.
// Ports:
//   y_lat_i  in  10  latched scanline
//   obj_y_i  in   9  object top line
//   valid_i  in   1  object valid flag
//   hit_o    out  1  object covers the scanline
// ---------------------------------------------------------------------------
module sprite_y_hit
    import sprite_pkg::*;
#(
    parameter int SPRITE_H = SPRITE_H_DEFAULT
) (
    input  logic [9:0] y_lat_i,
    input  logic [8:0] obj_y_i,
    input  logic       valid_i,
    output logic       hit_o
);

    localparam logic [9:0] HEIGHT = 10'(SPRITE_H);

    logic [9:0] diff;

    // The y_lat >= y term rejects the modular wrap of the subtraction.
    assign diff  = y_lat_i - {1'b0, obj_y_i};
    assign hit_o = valid_i && (y_lat_i >= {1'b0, obj_y_i}) && (diff < HEIGHT);

endmodule

// File: rtl/sprite_line_scheduler.sv
// ---------------------------------------------------------------------------
// sprite_line_scheduler
// Per-scanline controller: on line_start it walks the object table, tests
// each valid entry for vertical overlap with the latched scanline and, for
// every hit, runs a start/ready handshake with the sprite fetcher.
// Optional feature macro: SPRITE_LIMIT_EN (per-line sprite cap + limit_hit).
// Ports:
//   clk50         in   1       system clock
//   reset         in   1       synchronous active-low reset
//   line_start    in   1       begin a scanline (pulse)
//   ycoor         in   10      scanline, sampled at line_start
//   obj_addr      out  ADDR_W  object table read address
//   obj_data      in   24      table data, valid one cycle after obj_addr
//   object_info   out  24      entry being drawn
//   sprite_start  out  1       start to fetcher
//   sprite_ready  in   1       ready from fetcher
//   busy          out  1       line in progress
//   line_done     out  1       line complete (pulse)
//   line_overrun  out  1       line_start arrived while busy (pulse)
//   sprites_drawn out  5       hits handshaken this line
//   limit_hit     out  1       cap reached (pulse with line_done), macro only
// ---------------------------------------------------------------------------
module sprite_line_scheduler
    import sprite_pkg::*;
#(
    parameter int NUM_OBJ      = 16,
    parameter int ADDR_W       = 4,
    parameter int SPRITE_H     = SPRITE_H_DEFAULT,
    parameter int MAX_PER_LINE = 8
) (
    input  logic              clk50,
    input  logic              reset,
    input  logic              line_start,
    input  logic [9:0]        ycoor,
    output logic [ADDR_W-1:0] obj_addr,
    input  logic [23:0]       obj_data,
    output logic [23:0]       object_info,
    output logic              sprite_start,
    input  logic              sprite_ready,
    output logic              busy,
    output logic              line_done,
    output logic              line_overrun,
    output logic [4:0]        sprites_drawn
`ifdef SPRITE_LIMIT_EN
    ,
    output logic              limit_hit
`endif
);

`ifdef SPRITE_LIMIT_EN
    localparam bit LIMIT_EN = 1'b1;
`else
    localparam bit LIMIT_EN = 1'b0;
`endif

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_OBJ - 1);
    localparam logic [4:0]        CAP      = 5'(MAX_PER_LINE);

    sched_st_t         state_q;
    logic [ADDR_W-1:0] idx_q;
    logic [9:0]        y_lat_q;
    logic [23:0]       object_info_q;
    logic              start_q;
    logic              busy_q;
    logic              done_q;
    logic [4:0]        drawn_q;
    logic              hit;
    logic              cap_reached;

    sprite_y_hit #(
        .SPRITE_H (SPRITE_H)
    ) u_y_hit (
        .y_lat_i (y_lat_q),
        .obj_y_i (obj_data[OBJ_Y_MSB:0]),
        .valid_i (obj_data[OBJ_VALID_BIT]),
        .hit_o   (hit)
    );

    assign cap_reached = LIMIT_EN && (drawn_q >= CAP);

    // The table read address is the scan index itself, so it is already
    // presented during FETCH and the data arrives in CHECK.
    always_ff @(posedge clk50) begin
        if (!reset) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            y_lat_q       <= '0;
            object_info_q <= '0;
            start_q       <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            drawn_q       <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (line_start) begin
                        y_lat_q <= ycoor;
                        idx_q   <= '0;
                        drawn_q <= '0;
                        busy_q  <= 1'b1;
                        state_q <= FETCH;
                    end
                end
                FETCH: state_q <= CHECK;
                CHECK: begin
                    if (hit) begin
                        object_info_q <= obj_data;
                        start_q       <= 1'b1;
                        state_q       <= START;
                    end else begin
                        state_q <= NEXT;
                    end
                end
                START: begin
                    if (sprite_ready) begin
                        start_q <= 1'b0;
                        if (drawn_q != 5'd31) begin
                            drawn_q <= drawn_q + 5'd1;
                        end
                        state_q <= RELEASE;
                    end
                end
                RELEASE: begin
                    // Wait for ready to fall so a held ready is not mistaken
                    // for the acknowledge of the next sprite.
                    if (!sprite_ready) begin
                        if (cap_reached) begin
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            state_q <= NEXT;
                        end
                    end
                end
                NEXT: begin
                    if (idx_q == LAST_IDX) begin
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        idx_q   <= idx_q + 1'b1;
                        state_q <= FETCH;
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef SPRITE_LIMIT_EN
    logic limit_hit_q;

    // Set on the same edge that enters DONE via the cap path.
    always_ff @(posedge clk50) begin
        if (!reset) begin
            limit_hit_q <= 1'b0;
        end else begin
            limit_hit_q <= (state_q == RELEASE) && !sprite_ready && cap_reached;
        end
    end

    assign limit_hit = limit_hit_q;
`endif

    // busy stays high through DONE, so a line_start there is an overrun too.
    assign line_overrun  = line_start && busy_q;
    assign obj_addr      = idx_q;
    assign object_info   = object_info_q;
    assign sprite_start  = start_q;
    assign busy          = busy_q;
    assign line_done     = done_q;
    assign sprites_drawn = drawn_q;

endmodule

// File: tb/tb_sprite_line_scheduler.sv
`timescale 1ns/1ps
module tb_sprite_line_scheduler;

    localparam int NUM_OBJ  = 16;
    localparam int ADDR_W   = 4;
    localparam int SPRITE_H = 32;
`ifdef SPRITE_LIMIT_EN
    localparam int MAX_PER_LINE = 2;
    localparam int LINE_CAP     = MAX_PER_LINE;
`else
    localparam int MAX_PER_LINE = 8;
    localparam int LINE_CAP     = 31;
`endif

    logic              clk50 = 1'b0;
    logic              reset = 1'b0;
    logic              line_start = 1'b0;
    logic [9:0]        ycoor = '0;
    logic [ADDR_W-1:0] obj_addr;
    logic [23:0]       obj_data = '0;
    logic [23:0]       object_info;
    logic              sprite_start;
    logic              sprite_ready = 1'b0;
    logic              busy;
    logic              line_done;
    logic              line_overrun;
    logic [4:0]        sprites_drawn;
`ifdef SPRITE_LIMIT_EN
    logic              limit_hit;
`endif

    int pass_cnt = 0;
    int total_cnt = 0;

    logic [23:0] obj_table [NUM_OBJ];
    logic [23:0] exp_q [$];
    bit          exp_limit;

    sprite_line_scheduler #(
        .NUM_OBJ      (NUM_OBJ),
        .ADDR_W       (ADDR_W),
        .SPRITE_H     (SPRITE_H),
        .MAX_PER_LINE (MAX_PER_LINE)
    ) dut (
        .clk50         (clk50),
        .reset         (reset),
        .line_start    (line_start),
        .ycoor         (ycoor),
        .obj_addr      (obj_addr),
        .obj_data      (obj_data),
        .object_info   (object_info),
        .sprite_start  (sprite_start),
        .sprite_ready  (sprite_ready),
        .busy          (busy),
        .line_done     (line_done),
        .line_overrun  (line_overrun),
        .sprites_drawn (sprites_drawn)
`ifdef SPRITE_LIMIT_EN
        ,
        .limit_hit     (limit_hit)
`endif
    );

    always #5 clk50 = ~clk50;

    // Object table with one-cycle registered read
    always @(posedge clk50) obj_data <= obj_table[obj_addr];

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [23:0] mk_entry(input bit v, input int id, input int x, input int y);
        logic [3:0] id4;
        logic [9:0] x10;
        logic [8:0] y9;
        id4 = id[3:0];
        x10 = x[9:0];
        y9  = y[8:0];
        return {v, id4, x10, y9};
    endfunction

    // Reference: scan in table order, an entry covers line y when it is valid
    // and y lies in [top, top + SPRITE_H).
    task automatic model_line(input int y);
        int ey;
        int total;
        exp_q.delete();
        total = 0;
        for (int i = 0; i < NUM_OBJ; i++) begin
            ey = int'(obj_table[i][8:0]);
            if (obj_table[i][23] && y >= ey && y < ey + SPRITE_H) begin
                total++;
                if (exp_q.size() < LINE_CAP) exp_q.push_back(obj_table[i]);
            end
        end
`ifdef SPRITE_LIMIT_EN
        exp_limit = (total >= MAX_PER_LINE);
`else
        exp_limit = 1'b0;
`endif
    endtask

    // hold_max < 0: random ready hold; overrun_cyc > 0: pulse line_start at
    // that cycle, -2: pulse during the line_done cycle; exp_latency > 0 checks
    // the cycle of line_done counted from line_start.
    task automatic run_line(input int y, input int hold_max, input int overrun_cyc,
                            input int exp_latency);
        logic [23:0] got_q [$];
        logic [23:0] held_info;
        int cyc, wait_cnt, hold_cnt, done_cyc, bad_hold, stale;
        bit prev_start, seen_done, got_limit;
        model_line(y);
        got_q.delete();
        held_info = '0; wait_cnt = 0; hold_cnt = 0; done_cyc = -1;
        bad_hold = 0; stale = 0; prev_start = 1'b0; seen_done = 1'b0; got_limit = 1'b0;
        @(negedge clk50);
        line_start = 1'b1;
        ycoor = y[9:0];
        @(negedge clk50);
        line_start = 1'b0;
        ycoor = 10'($urandom);
        chk_eq("busy_up", 32'(busy), 32'd1);
        cyc = 1;
        while (!seen_done && cyc < 3000) begin
            if (sprite_start && !prev_start) begin
                got_q.push_back(object_info);
                held_info = object_info;
                wait_cnt = $urandom_range(3, 0);
                if (sprite_ready) stale++;
            end
            if (sprite_start && object_info !== held_info) bad_hold++;
            if (sprite_start && !sprite_ready) begin
                if (wait_cnt == 0) begin
                    sprite_ready = 1'b1;
                    hold_cnt = (hold_max < 0) ? $urandom_range(3, 0) : hold_max;
                end else begin
                    wait_cnt--;
                end
            end else if (!sprite_start && sprite_ready) begin
                if (hold_cnt == 0) sprite_ready = 1'b0;
                else hold_cnt--;
            end
            prev_start = sprite_start;
            if (line_done) begin
                seen_done = 1'b1;
                done_cyc = cyc;
`ifdef SPRITE_LIMIT_EN
                got_limit = limit_hit;
`endif
            end
            if (overrun_cyc > 0 && cyc == overrun_cyc) begin
                line_start = 1'b1;
                ycoor = 10'($urandom);
                #1 chk_eq("overrun_pulse", 32'(line_overrun), 32'd1);
            end
            if (overrun_cyc > 0 && cyc == overrun_cyc + 1) begin
                line_start = 1'b0;
                #1 chk_eq("overrun_clear", 32'(line_overrun), 32'd0);
            end
            if (overrun_cyc == -2 && line_done) begin
                line_start = 1'b1;
                #1 chk_eq("overrun_at_done", 32'(line_overrun), 32'd1);
            end
            if (!seen_done) begin
                cyc++;
                @(negedge clk50);
            end
        end
        if (!seen_done) chk_eq("done_timeout", 32'd0, 32'd1);
        @(negedge clk50);
        line_start = 1'b0;
        chk_eq("done_one_cycle", 32'(line_done), 32'd0);
        chk_eq("busy_drop", 32'(busy), 32'd0);
        chk_eq("sprites_drawn", 32'(sprites_drawn), 32'(exp_q.size()));
        chk_eq("handshake_cnt", 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk_eq($sformatf("object_info[%0d]", i), 32'(got_q[i]), 32'(exp_q[i]));
        chk_eq("stale_ready", 32'(stale), 32'd0);
        chk_eq("info_stable", 32'(bad_hold), 32'd0);
`ifdef SPRITE_LIMIT_EN
        chk_eq("limit_hit", 32'(got_limit), 32'(exp_limit));
`endif
        if (exp_latency > 0) chk_eq("done_latency", 32'(done_cyc), 32'(exp_latency));
        $display("line y=%0d hits=%0d drawn=%0d done_cyc=%0d limit=%0d",
                 y, exp_q.size(), sprites_drawn, done_cyc, got_limit);
    endtask

    task automatic reset_mid_start();
        int n;
        for (int i = 0; i < NUM_OBJ; i++) obj_table[i] = '0;
        obj_table[0] = mk_entry(1'b1, 2, 40, 50);
        @(negedge clk50);
        line_start = 1'b1;
        ycoor = 10'd60;
        @(negedge clk50);
        line_start = 1'b0;
        n = 0;
        while (!sprite_start && n < 200) begin
            @(negedge clk50);
            n++;
        end
        chk_eq("rst_reach_start", 32'(sprite_start), 32'd1);
        reset = 1'b0;
        @(negedge clk50);
        chk_eq("rst_start_drop", 32'(sprite_start), 32'd0);
        chk_eq("rst_busy_drop", 32'(busy), 32'd0);
        chk_eq("rst_info_clear", 32'(object_info), 32'd0);
        chk_eq("rst_drawn_clear", 32'(sprites_drawn), 32'd0);
        reset = 1'b1;
        @(negedge clk50);
        $display("reset during handshake after %0d cycles", n);
    endtask

    initial begin
        int ly, ey;
        for (int i = 0; i < NUM_OBJ; i++) obj_table[i] = '0;
        repeat (3) @(negedge clk50);
        chk_eq("rst_sprite_start", 32'(sprite_start), 32'd0);
        chk_eq("rst_busy", 32'(busy), 32'd0);
        chk_eq("rst_line_done", 32'(line_done), 32'd0);
        chk_eq("rst_obj_addr", 32'(obj_addr), 32'd0);
        chk_eq("rst_object_info", 32'(object_info), 32'd0);
        chk_eq("rst_sprites_drawn", 32'(sprites_drawn), 32'd0);
        chk_eq("rst_line_overrun", 32'(line_overrun), 32'd0);
        reset = 1'b1;
        @(negedge clk50);

        // Empty table: fixed 16 x 3 scan plus DONE
        run_line(100, 0, 0, 49);

        // Single entry at y=90, x=200
        obj_table[3] = mk_entry(1'b1, 5, 200, 90);
        run_line(100, -1, 0, 0);
        chk_eq("info_x_field", 32'(object_info[18:9]), 32'd200);
        run_line(121, -1, 0, 0);
        run_line(122, -1, 0, 0);

        // Two hits with ready held 5 cycles after start drops
        obj_table[4] = mk_entry(1'b1, 6, 300, 95);
        run_line(100, 5, 0, 0);

        // Overrun mid-line and in the line_done cycle
        run_line(100, -1, 10, 0);
        run_line(100, -1, -2, 0);

        // Bottom-of-range object and the wrapped scanline
        obj_table[5] = mk_entry(1'b1, 1, 0, 511);
        run_line(520, -1, 0, 0);
        run_line(5, -1, 0, 0);

        // Four hitting entries (cap case when the limit is built in)
        for (int i = 0; i < NUM_OBJ; i++) obj_table[i] = '0;
        for (int i = 0; i < 4; i++) obj_table[i * 3] = mk_entry(1'b1, i, 10 * i, 200 + i);
        run_line(210, -1, 0, 0);

        // Randomized tables and scanlines
        for (int t = 0; t < 12; t++) begin
            ly = $urandom_range(600, 0);
            for (int i = 0; i < NUM_OBJ; i++) begin
                ey = $urandom_range(1, 0) ? (ly - $urandom_range(40, 0)) : $urandom_range(511, 0);
                if (ey < 0) ey = 0;
                obj_table[i] = mk_entry($urandom_range(99, 0) < 50, $urandom_range(15, 0),
                                        $urandom_range(1023, 0), ey & 511);
            end
            run_line(ly, -1, 0, 0);
        end

        reset_mid_start();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
